// File: rtl/pixel_line_scaler.sv
// Integer upscaler: ping-pong line buffers fed over a req/ack port.
// Optional mirroring is enabled with PIXEL_LINE_SCALER_MIRROR_EN.
module pixel_line_scaler #(
  parameter int PIX_W   = 4,
  parameter int H_PIX   = 64,
  parameter int V_PIX   = 48,
  parameter int SCALE_H = 10,
  parameter int SCALE_V = 10,
  parameter int SEL_W   = 3,
  parameter int ADDR_W  = 9
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              disp_active,
  input  logic              line_end,
  input  logic              frame_end,
`ifdef PIXEL_LINE_SCALER_MIRROR_EN
  input  logic              mirror_h,
  input  logic              mirror_v,
`endif
  output logic [PIX_W-1:0]  pixel_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_sel,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic              fetching,
  output logic              underrun
);

  localparam int HC_W  = (SCALE_H > 1) ? $clog2(SCALE_H) : 1;
  localparam int VC_W  = (SCALE_V > 1) ? $clog2(SCALE_V) : 1;
  localparam int HP_W  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int VR_W  = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int LIN_W = ADDR_W + SEL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  logic [PIX_W-1:0] r_buf0 [H_PIX];
  logic [PIX_W-1:0] r_buf1 [H_PIX];

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_front_sel;
  logic             r_front_valid;
  logic             r_back_valid;
  logic [HC_W-1:0]  r_h_cnt;
  logic [HP_W-1:0]  r_h_pix;
  logic [VC_W-1:0]  r_v_cnt;
  logic [VR_W-1:0]  r_v_row;
  logic             r_line_seen;
  logic [PIX_W-1:0] r_pixel;
  logic [VR_W-1:0]  r_row;
  logic [HP_W-1:0]  r_col;
  logic             r_fill;
  logic             r_disc;
  logic             r_pend;
  logic [VR_W-1:0]  r_pend_row;
  logic             r_pend_fill;
  logic             r_fill_swap;
  logic             r_underrun;

  logic             w_mir_h;
  logic             w_mir_v;
  logic             w_mir_v_fe;
  logic [HP_W-1:0]  w_rd_idx;
  logic [PIX_W-1:0] w_front_pix;
  logic             w_seen;
  logic             w_v_last;
  logic [VR_W-1:0]  w_v_row_inc;
  logic             w_line_swap;
  logic             w_swap;
  logic [VR_W-1:0]  w_swap_row;
  logic             w_tgt_ok;
  logic [VR_W-1:0]  w_tgt_log;
  logic [VR_W-1:0]  w_tgt_row;
  logic [VR_W-1:0]  w_row0;
  logic             w_new_vld;
  logic             w_new_ok;
  logic [VR_W-1:0]  w_new_row;
  logic             w_new_fill;
  logic             w_last;
  logic [LIN_W-1:0] w_lin;

  logic             w_load;
  logic [VR_W-1:0]  w_ld_row;
  logic             w_ld_fill;
  logic             w_wr;
  logic             w_done;
  logic             w_disc_nxt;
  logic             w_pend_nxt;
  logic [VR_W-1:0]  w_pend_row_nxt;
  logic             w_pend_fill_nxt;

`ifdef PIXEL_LINE_SCALER_MIRROR_EN
  logic r_mir_h;
  logic r_mir_v;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_mir_h <= 1'b0;
      r_mir_v <= 1'b0;
    end else if (frame_end) begin
      r_mir_h <= mirror_h;
      r_mir_v <= mirror_v;
    end
  end

  assign w_mir_h    = r_mir_h;
  assign w_mir_v    = r_mir_v;
  assign w_mir_v_fe = mirror_v;
`else
  assign w_mir_h    = 1'b0;
  assign w_mir_v    = 1'b0;
  assign w_mir_v_fe = 1'b0;
`endif

  assign w_rd_idx = w_mir_h ? HP_W'(H_PIX - 1) - r_h_pix
                            : r_h_pix;
  assign w_front_pix = r_front_sel ? r_buf1[w_rd_idx]
                                   : r_buf0[w_rd_idx];

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_h_pix <= '0;
    end else if (line_end) begin
      r_h_cnt <= '0;
      r_h_pix <= '0;
    end else if (disp_active) begin
      if (r_h_cnt == HC_W'(SCALE_H - 1)) begin
        r_h_cnt <= '0;
        if (r_h_pix != HP_W'(H_PIX - 1))
          r_h_pix <= r_h_pix + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n)
      r_pixel <= '0;
    else if (disp_active && r_front_valid)
      r_pixel <= w_front_pix;
    else
      r_pixel <= '0;
  end

  // a line counts only if some visible pixel was seen in it
  assign w_seen      = r_line_seen | disp_active;
  assign w_v_last    = (r_v_cnt == VC_W'(SCALE_V - 1));
  assign w_v_row_inc = (r_v_row == VR_W'(V_PIX - 1)) ? '0
                                                      : r_v_row + 1'b1;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_v_cnt     <= '0;
      r_v_row     <= '0;
      r_line_seen <= 1'b0;
    end else if (frame_end) begin
      r_v_cnt     <= '0;
      r_v_row     <= '0;
      r_line_seen <= 1'b0;
    end else if (line_end) begin
      r_line_seen <= 1'b0;
      if (w_seen) begin
        if (w_v_last) begin
          r_v_cnt <= '0;
          r_v_row <= w_v_row_inc;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end
    end else if (disp_active) begin
      r_line_seen <= 1'b1;
    end
  end

  assign w_line_swap = line_end & ~frame_end & w_seen & w_v_last;
  assign w_swap      = w_line_swap | (r_fill_swap & ~frame_end);
  assign w_swap_row  = w_line_swap ? w_v_row_inc : r_v_row;
  assign w_tgt_ok    = (w_swap_row != VR_W'(V_PIX - 1));
  assign w_tgt_log   = w_swap_row + 1'b1;
  assign w_tgt_row   = w_mir_v ? VR_W'(V_PIX - 1) - w_tgt_log
                               : w_tgt_log;
  assign w_row0      = w_mir_v_fe ? VR_W'(V_PIX - 1) : '0;

  assign w_new_vld  = frame_end | w_swap;
  assign w_new_ok   = frame_end | w_tgt_ok;
  assign w_new_row  = frame_end ? w_row0 : w_tgt_row;
  assign w_new_fill = frame_end;
  assign w_last     = (r_col == HP_W'(H_PIX - 1));

  always_ff @(posedge clk_25) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_ld_row        = w_new_row;
    w_ld_fill       = w_new_fill;
    w_wr            = 1'b0;
    w_done          = 1'b0;
    w_disc_nxt      = r_disc;
    w_pend_nxt      = r_pend;
    w_pend_row_nxt  = r_pend_row;
    w_pend_fill_nxt = r_pend_fill;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_new_vld) begin
          if (w_new_ok) begin
            w_load      = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_REQ: begin
        // a request in flight is never withdrawn; its data is dropped
        if (w_new_vld) begin
          w_disc_nxt      = 1'b1;
          w_pend_nxt      = w_new_ok;
          w_pend_row_nxt  = w_new_row;
          w_pend_fill_nxt = w_new_fill;
        end
        if (mem_ack) begin
          if (w_disc_nxt) begin
            if (w_pend_nxt) begin
              w_load    = 1'b1;
              w_ld_row  = w_pend_row_nxt;
              w_ld_fill = w_pend_fill_nxt;
            end else begin
              w_state_nxt = S_IDLE;
            end
            w_disc_nxt = 1'b0;
            w_pend_nxt = 1'b0;
          end else begin
            w_wr = 1'b1;
            if (w_last) begin
              w_state_nxt = S_DONE;
              w_done      = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_row         <= '0;
      r_col         <= '0;
      r_fill        <= 1'b0;
      r_disc        <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_row    <= '0;
      r_pend_fill   <= 1'b0;
      r_fill_swap   <= 1'b0;
      r_underrun    <= 1'b0;
      r_front_sel   <= 1'b0;
      r_front_valid <= 1'b0;
      r_back_valid  <= 1'b0;
    end else begin
      r_disc      <= w_disc_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_row  <= w_pend_row_nxt;
      r_pend_fill <= w_pend_fill_nxt;
      r_fill_swap <= w_done & r_fill;
      if (w_swap && r_state == S_REQ)
        r_underrun <= 1'b1;
      if (w_swap) begin
        r_front_sel   <= ~r_front_sel;
        r_front_valid <= r_back_valid;
        r_back_valid  <= 1'b0;
      end
      if (w_load) begin
        r_row        <= w_ld_row;
        r_col        <= '0;
        r_fill       <= w_ld_fill;
        r_back_valid <= 1'b0;
      end else if (w_wr && !w_last) begin
        r_col <= r_col + 1'b1;
      end
      if (w_done)
        r_back_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (w_wr) begin
      if (r_front_sel)
        r_buf0[r_col] <= mem_data;
      else
        r_buf1[r_col] <= mem_data;
    end
  end

  assign w_lin = LIN_W'(r_row) * LIN_W'(H_PIX) + LIN_W'(r_col);

  assign pixel_out = r_pixel;
  assign mem_req   = (r_state == S_REQ);
  assign mem_addr  = w_lin[LIN_W-1:SEL_W];
  assign mem_sel   = w_lin[SEL_W-1:0];
  assign fetching  = (r_state != S_IDLE);
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_pixel_line_scaler.sv
// Scoreboard bench for pixel_line_scaler; memory pixel(i) = (i + i/64) mod 16,
// so row 0 holds i mod 16 and each later row is shifted by its row number.
module tb_pixel_line_scaler;

  localparam int PIX_W   = 4;
  localparam int H_PIX   = 64;
  localparam int V_PIX   = 48;
  localparam int SCALE_H = 10;
  localparam int SCALE_V = 10;
  localparam int SEL_W   = 3;
  localparam int ADDR_W  = 9;

  logic              clk_25 = 1'b0;
  logic              rst_n;
  logic              disp_active;
  logic              line_end;
  logic              frame_end;
  logic              mirror_h;
  logic              mirror_v;
  logic [PIX_W-1:0]  pixel_out;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [SEL_W-1:0]  mem_sel;
  logic              mem_ack;
  logic [PIX_W-1:0]  mem_data;
  logic              fetching;
  logic              underrun;
  logic              ack_en;

  int n_assert = 0;
  int n_fail   = 0;
  logic [PIX_W-1:0] sb[$];
  int exp_row = 0;
  bit exp_fv  = 1'b0;
  bit exp_mir = 1'b0;

  always #20 clk_25 = ~clk_25;

  function automatic logic [PIX_W-1:0] mem_pix(input int i);
    return PIX_W'((i + i / H_PIX) % 16);
  endfunction

  function automatic logic [PIX_W-1:0] exp_pix(input int c);
    int src;
    src = c / SCALE_H;
    if (exp_mir) src = H_PIX - 1 - src;
    return mem_pix(exp_row * H_PIX + src);
  endfunction

  assign mem_ack  = ack_en;
  assign mem_data = ack_en ? mem_pix(int'({mem_addr, mem_sel})) : '0;

  pixel_line_scaler #(
    .PIX_W(PIX_W), .H_PIX(H_PIX), .V_PIX(V_PIX),
    .SCALE_H(SCALE_H), .SCALE_V(SCALE_V),
    .SEL_W(SEL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_25(clk_25),
    .rst_n(rst_n),
    .disp_active(disp_active),
    .line_end(line_end),
    .frame_end(frame_end),
`ifdef PIXEL_LINE_SCALER_MIRROR_EN
    .mirror_h(mirror_h),
    .mirror_v(mirror_v),
`endif
    .pixel_out(pixel_out),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_sel(mem_sel),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .fetching(fetching),
    .underrun(underrun)
  );

  // One raster line: 640 visible cycles (if act), blanking, line_end pulse.
  task automatic run_line(input bit act, input bit chk);
    logic [PIX_W-1:0] e;
    int n;
    n = act ? 645 : 5;
    sb.delete();
    for (int c = 0; c <= n; c++) begin
      @(negedge clk_25);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (chk) begin
          n_assert++;
          if (pixel_out !== e) begin
            n_fail++;
            $display("FAIL pixel row=%0d col=%0d got %0d want %0d",
                     exp_row, c - 1, pixel_out, e);
          end
        end
      end
      if (c < n) begin
        disp_active = act && (c < 640);
        line_end    = (c == n - 1);
        sb.push_back((disp_active && exp_fv) ? exp_pix(c) : '0);
      end else begin
        disp_active = 1'b0;
        line_end    = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    disp_active = 1'b0;
    line_end = 1'b0;
    frame_end = 1'b0;
    mirror_h = 1'b0;
    mirror_v = 1'b0;
    ack_en = 1'b0;
    repeat (3) @(negedge clk_25);
    n_assert++;
    if ({pixel_out, mem_req, mem_addr, mem_sel, fetching, underrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got pix=%0d req=%0d addr=%0d sel=%0d fetch=%0d und=%0d want all 0",
               pixel_out, mem_req, mem_addr, mem_sel, fetching, underrun);
    end
    rst_n = 1'b1;
    disp_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25);
      n_assert++;
      if (mem_req !== 1'b0 || pixel_out !== '0 || underrun !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_req cyc=%0d got req=%0d pix=%0d und=%0d want 0/0/0",
                 i, mem_req, pixel_out, underrun);
      end
    end
    disp_active = 1'b0;
    line_end = 1'b1;
    @(negedge clk_25);
    line_end = 1'b0;
  endtask

  task automatic test_frame_fill();
    @(negedge clk_25);
    frame_end = 1'b1;
    @(negedge clk_25);
    frame_end = 1'b0;
    ack_en = 1'b1;
    for (int k = 0; k < H_PIX; k++) begin
      if (k != 0) @(negedge clk_25);
      n_assert++;
      if (mem_req !== 1'b1 || fetching !== 1'b1 ||
          mem_addr !== ADDR_W'(k / 8) || mem_sel !== SEL_W'(k % 8)) begin
        n_fail++;
        $display("FAIL fill_ack k=%0d got req=%0d addr=%0d sel=%0d want 1/%0d/%0d",
                 k, mem_req, mem_addr, mem_sel, k / 8, k % 8);
      end
    end
    @(negedge clk_25);
    ack_en = 1'b0;
    n_assert++;
    if (mem_req !== 1'b0 || fetching !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done got req=%0d fetch=%0d want 0/1", mem_req, fetching);
    end
    @(negedge clk_25);
    n_assert++;
    if (mem_req !== 1'b1 || {mem_addr, mem_sel} !== 12'd64) begin
      n_fail++;
      $display("FAIL row1_start got req=%0d lin=%0d want 1/64",
               mem_req, {mem_addr, mem_sel});
    end
    exp_row = 0;
    exp_fv = 1'b1;
  endtask

  task automatic test_active_line();
    ack_en = 1'b1;
    run_line(1'b1, 1'b1);
    ack_en = 1'b0;
    n_assert++;
    if (mem_req !== 1'b0 || fetching !== 1'b1) begin
      n_fail++;
      $display("FAIL row1_done got req=%0d fetch=%0d want 0/1", mem_req, fetching);
    end
  endtask

  task automatic test_line_count();
    run_line(1'b0, 1'b1);
    run_line(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) run_line(1'b1, 1'b1);
    run_line(1'b0, 1'b1);
    run_line(1'b1, 1'b1);
    n_assert++;
    if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(16) ||
        mem_sel !== '0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL row2_start got req=%0d addr=%0d sel=%0d und=%0d want 1/16/0/0",
               mem_req, mem_addr, mem_sel, underrun);
    end
    exp_row = 1;
    run_line(1'b1, 1'b1);
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 8; i++) begin
      run_line(1'b1, 1'b0);
      n_assert++;
      if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(16) || mem_sel !== '0) begin
        n_fail++;
        $display("FAIL req_hold line=%0d got req=%0d addr=%0d sel=%0d want 1/16/0",
                 i, mem_req, mem_addr, mem_sel);
      end
    end
    run_line(1'b1, 1'b1);
    n_assert++;
    if (underrun !== 1'b1 || mem_req !== 1'b1 ||
        mem_addr !== ADDR_W'(16) || mem_sel !== '0) begin
      n_fail++;
      $display("FAIL underrun_set got und=%0d req=%0d addr=%0d sel=%0d want 1/1/16/0",
               underrun, mem_req, mem_addr, mem_sel);
    end
    exp_fv = 1'b0;
    ack_en = 1'b1;
    @(negedge clk_25);
    n_assert++;
    if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(24) || mem_sel !== '0) begin
      n_fail++;
      $display("FAIL restart_row3 got req=%0d addr=%0d sel=%0d want 1/24/0",
               mem_req, mem_addr, mem_sel);
    end
    repeat (70) @(negedge clk_25);
    ack_en = 1'b0;
    n_assert++;
    if (underrun !== 1'b1 || mem_req !== 1'b0 || fetching !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky got und=%0d req=%0d fetch=%0d want 1/0/1",
               underrun, mem_req, fetching);
    end
    run_line(1'b1, 1'b1);
  endtask

`ifdef PIXEL_LINE_SCALER_MIRROR_EN
  task automatic test_mirror();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_25);
    rst_n = 1'b1;
    mirror_h = 1'b1;
    frame_end = 1'b1;
    @(negedge clk_25);
    frame_end = 1'b0;
    ack_en = 1'b1;
    repeat (70) @(negedge clk_25);
    ack_en = 1'b0;
    exp_row = 0;
    exp_fv = 1'b1;
    exp_mir = 1'b1;
    run_line(1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_frame_fill();
    test_active_line();
    test_line_count();
    test_underrun();
`ifdef PIXEL_LINE_SCALER_MIRROR_EN
    test_mirror();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
